// File: rtl/pico_l15_bridge.sv
// pico_l15_bridge
//   Bridges a PicoRV32 native memory port to the OpenPiton L1.5 core
//   interface. One Pico access becomes one L1.5 request. The bridge then
//   waits for the matching return and hands read data back to Pico.
//   L1.5 interrupt returns are turned into a one-cycle pico_int pulse.
//
//   Optional feature macro: PICO_L15_AMO_EN
//     defined   : a nonzero pico_mem_amo_op issues an AMO request (rqtype 6)
//     undefined : amo_op is ignored and transducer_l15_amo_op is tied to 0
//
//   Handshakes:
//     Pico side : pico_mem_valid is held until transducer_pico_mem_ready.
//                 ready is a single-cycle pulse and carries rdata.
//     L1.5 req  : transducer_l15_val stays high with stable fields until
//                 l15_transducer_ack or l15_transducer_header_ack.
//     L1.5 ret  : every l15_transducer_val cycle is consumed, so
//                 transducer_l15_req_ack follows it combinationally.
//
//   Ports:
//     clk, rst                        clock, synchronous active-high reset
//     pico_mem_*                      Pico request (valid/addr/wstrb/wdata/amo_op)
//     transducer_pico_mem_ready/rdata completion pulse and load data
//     pico_int                        interrupt pulse
//     transducer_l15_*                L1.5 request fields plus constant tie-offs
//     l15_transducer_ack/header_ack   L1.5 request accept
//     l15_transducer_val/returntype/data_0/data_1   L1.5 return
//     transducer_l15_req_ack          return consumed
//     fsm_state                       debug view: 0=IDLE 1=REQ 2=WAIT 3=RESP
module pico_l15_bridge #(
    parameter int PHY_ADDR_WIDTH = 40,
    parameter int AMO_OP_WIDTH   = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      pico_mem_valid,
    input  logic [31:0]               pico_mem_addr,
    input  logic [3:0]                pico_mem_wstrb,
    input  logic [31:0]               pico_mem_wdata,
    input  logic [AMO_OP_WIDTH-1:0]   pico_mem_amo_op,
    input  logic                      l15_transducer_ack,
    input  logic                      l15_transducer_header_ack,
    output logic [4:0]                transducer_l15_rqtype,
    output logic [AMO_OP_WIDTH-1:0]   transducer_l15_amo_op,
    output logic [2:0]                transducer_l15_size,
    output logic                      transducer_l15_val,
    output logic [PHY_ADDR_WIDTH-1:0] transducer_l15_address,
    output logic [63:0]               transducer_l15_data,
    output logic                      transducer_l15_nc,
    output logic [0:0]                transducer_l15_threadid,
    output logic                      transducer_l15_prefetch,
    output logic                      transducer_l15_invalidate_cacheline,
    output logic                      transducer_l15_blockstore,
    output logic                      transducer_l15_blockinitstore,
    output logic [1:0]                transducer_l15_l1rplway,
    output logic [63:0]               transducer_l15_data_next_entry,
    output logic [32:0]               transducer_l15_csm_data,
    input  logic                      l15_transducer_val,
    input  logic [3:0]                l15_transducer_returntype,
    input  logic [63:0]               l15_transducer_data_0,
    input  logic [63:0]               l15_transducer_data_1,
    output logic                      transducer_pico_mem_ready,
    output logic [31:0]               transducer_pico_mem_rdata,
    output logic                      transducer_l15_req_ack,
    output logic                      pico_int,
    output logic [1:0]                fsm_state
);

    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, RESP = 2'd3} state_t;

    localparam logic [4:0] RQ_LOAD    = 5'd0;
    localparam logic [4:0] RQ_STORE   = 5'd1;
    localparam logic [4:0] RQ_AMO     = 5'd6;
    localparam logic [3:0] RET_LOAD   = 4'd0;
    localparam logic [3:0] RET_ATOMIC = 4'd3;
    localparam logic [3:0] RET_ST_ACK = 4'd4;
    localparam logic [3:0] RET_INT    = 4'd7;

    function automatic logic [31:0] bswap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    state_t state;
    logic   addr_bit2_q;   // selects which half of data_0 holds the word

    // Request shape: byte and aligned-halfword strobes give narrow accesses
    // whose offset is the position of the lowest enabled byte; everything
    // else (including loads) is a word-aligned 4-byte access.
    logic [2:0] dec_size;
    logic [1:0] dec_offset;
    logic       dec_amo;
    logic [4:0] dec_rqtype;

    always_comb begin
        dec_size   = 3'd2;
        dec_offset = 2'd0;
        case (pico_mem_wstrb)
            4'b0001: begin dec_size = 3'd0; dec_offset = 2'd0; end
            4'b0010: begin dec_size = 3'd0; dec_offset = 2'd1; end
            4'b0100: begin dec_size = 3'd0; dec_offset = 2'd2; end
            4'b1000: begin dec_size = 3'd0; dec_offset = 2'd3; end
            4'b0011: begin dec_size = 3'd1; dec_offset = 2'd0; end
            4'b1100: begin dec_size = 3'd1; dec_offset = 2'd2; end
            default: ;
        endcase
    end

`ifdef PICO_L15_AMO_EN
    assign dec_amo = (pico_mem_amo_op != '0);
`else
    assign dec_amo = 1'b0;
`endif

    always_comb begin
        dec_rqtype = RQ_LOAD;
        if (dec_amo)
            dec_rqtype = RQ_AMO;
        else if (pico_mem_wstrb != 4'b0000)
            dec_rqtype = RQ_STORE;
    end

    // Every return is consumed the cycle it appears, whatever the state.
    assign transducer_l15_req_ack = l15_transducer_val;
    assign fsm_state              = state;

    assign transducer_l15_threadid             = 1'b0;
    assign transducer_l15_prefetch             = 1'b0;
    assign transducer_l15_invalidate_cacheline = 1'b0;
    assign transducer_l15_blockstore           = 1'b0;
    assign transducer_l15_blockinitstore       = 1'b0;
    assign transducer_l15_l1rplway             = 2'b00;
    assign transducer_l15_data_next_entry      = 64'd0;
    assign transducer_l15_csm_data             = 33'd0;

`ifdef PICO_L15_AMO_EN
    always_ff @(posedge clk) begin
        if (rst)
            transducer_l15_amo_op <= '0;
        else if (state == IDLE && pico_mem_valid)
            transducer_l15_amo_op <= pico_mem_amo_op;
    end
`else
    assign transducer_l15_amo_op = '0;
`endif

    // Inputs that carry no information for this bridge.
    logic unused_inputs;
    assign unused_inputs = ^{l15_transducer_data_1, pico_mem_amo_op, pico_mem_addr[1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state                     <= IDLE;
            addr_bit2_q               <= 1'b0;
            transducer_l15_val        <= 1'b0;
            transducer_l15_rqtype     <= '0;
            transducer_l15_size       <= '0;
            transducer_l15_address    <= '0;
            transducer_l15_data       <= '0;
            transducer_l15_nc         <= 1'b0;
            transducer_pico_mem_ready <= 1'b0;
            transducer_pico_mem_rdata <= '0;
            pico_int                  <= 1'b0;
        end else begin
            // Interrupt returns are independent of the request FSM.
            pico_int <= l15_transducer_val && (l15_transducer_returntype == RET_INT);

            case (state)
                IDLE: begin
                    if (pico_mem_valid) begin
                        state                  <= REQ;
                        transducer_l15_val     <= 1'b1;
                        transducer_l15_rqtype  <= dec_rqtype;
                        transducer_l15_size    <= dec_size;
                        transducer_l15_address <= {{(PHY_ADDR_WIDTH-32){1'b0}},
                                                   pico_mem_addr[31:2], dec_offset};
                        transducer_l15_data    <= {bswap32(pico_mem_wdata), bswap32(pico_mem_wdata)};
                        transducer_l15_nc      <= pico_mem_addr[31];
                        addr_bit2_q            <= pico_mem_addr[2];
                    end
                end
                REQ: begin
                    if (l15_transducer_ack || l15_transducer_header_ack) begin
                        state              <= WAIT;
                        transducer_l15_val <= 1'b0;
                    end
                end
                WAIT: begin
                    // Anything other than a completion type is acked and dropped.
                    if (l15_transducer_val &&
                        (l15_transducer_returntype == RET_LOAD   ||
                         l15_transducer_returntype == RET_ST_ACK ||
                         l15_transducer_returntype == RET_ATOMIC)) begin
                        state                     <= RESP;
                        transducer_pico_mem_ready <= 1'b1;
                        if (l15_transducer_returntype == RET_ST_ACK)
                            transducer_pico_mem_rdata <= '0;
                        else
                            transducer_pico_mem_rdata <= bswap32(addr_bit2_q ? l15_transducer_data_0[31:0]
                                                                             : l15_transducer_data_0[63:32]);
                    end
                end
                RESP: begin
                    state                     <= IDLE;
                    transducer_pico_mem_ready <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pico_l15_bridge.sv
// Self-checking bench for pico_l15_bridge. Inputs are driven and outputs
// sampled on the falling clock edge; the DUT works on the rising edge.
module tb_pico_l15_bridge;

    localparam int PAW = 40;
    localparam int AW  = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            pico_mem_valid;
    logic [31:0]     pico_mem_addr;
    logic [3:0]      pico_mem_wstrb;
    logic [31:0]     pico_mem_wdata;
    logic [AW-1:0]   pico_mem_amo_op;
    logic            l15_transducer_ack;
    logic            l15_transducer_header_ack;
    logic [4:0]      transducer_l15_rqtype;
    logic [AW-1:0]   transducer_l15_amo_op;
    logic [2:0]      transducer_l15_size;
    logic            transducer_l15_val;
    logic [PAW-1:0]  transducer_l15_address;
    logic [63:0]     transducer_l15_data;
    logic            transducer_l15_nc;
    logic [0:0]      transducer_l15_threadid;
    logic            transducer_l15_prefetch;
    logic            transducer_l15_invalidate_cacheline;
    logic            transducer_l15_blockstore;
    logic            transducer_l15_blockinitstore;
    logic [1:0]      transducer_l15_l1rplway;
    logic [63:0]     transducer_l15_data_next_entry;
    logic [32:0]     transducer_l15_csm_data;
    logic            l15_transducer_val;
    logic [3:0]      l15_transducer_returntype;
    logic [63:0]     l15_transducer_data_0;
    logic [63:0]     l15_transducer_data_1;
    logic            transducer_pico_mem_ready;
    logic [31:0]     transducer_pico_mem_rdata;
    logic            transducer_l15_req_ack;
    logic            pico_int;
    logic [1:0]      fsm_state;

    pico_l15_bridge #(.PHY_ADDR_WIDTH(PAW), .AMO_OP_WIDTH(AW)) dut (
        .clk                                 (clk),
        .rst                                 (rst),
        .pico_mem_valid                      (pico_mem_valid),
        .pico_mem_addr                       (pico_mem_addr),
        .pico_mem_wstrb                      (pico_mem_wstrb),
        .pico_mem_wdata                      (pico_mem_wdata),
        .pico_mem_amo_op                     (pico_mem_amo_op),
        .l15_transducer_ack                  (l15_transducer_ack),
        .l15_transducer_header_ack           (l15_transducer_header_ack),
        .transducer_l15_rqtype               (transducer_l15_rqtype),
        .transducer_l15_amo_op               (transducer_l15_amo_op),
        .transducer_l15_size                 (transducer_l15_size),
        .transducer_l15_val                  (transducer_l15_val),
        .transducer_l15_address              (transducer_l15_address),
        .transducer_l15_data                 (transducer_l15_data),
        .transducer_l15_nc                   (transducer_l15_nc),
        .transducer_l15_threadid             (transducer_l15_threadid),
        .transducer_l15_prefetch             (transducer_l15_prefetch),
        .transducer_l15_invalidate_cacheline (transducer_l15_invalidate_cacheline),
        .transducer_l15_blockstore           (transducer_l15_blockstore),
        .transducer_l15_blockinitstore       (transducer_l15_blockinitstore),
        .transducer_l15_l1rplway             (transducer_l15_l1rplway),
        .transducer_l15_data_next_entry      (transducer_l15_data_next_entry),
        .transducer_l15_csm_data             (transducer_l15_csm_data),
        .l15_transducer_val                  (l15_transducer_val),
        .l15_transducer_returntype           (l15_transducer_returntype),
        .l15_transducer_data_0               (l15_transducer_data_0),
        .l15_transducer_data_1               (l15_transducer_data_1),
        .transducer_pico_mem_ready           (transducer_pico_mem_ready),
        .transducer_pico_mem_rdata           (transducer_pico_mem_rdata),
        .transducer_l15_req_ack              (transducer_l15_req_ack),
        .pico_int                            (pico_int),
        .fsm_state                           (fsm_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_q[$];

    // ---------------- reference model ----------------
    function automatic logic [31:0] swap_bytes(input logic [31:0] w);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = w[8*(3-i) +: 8];
        return r;
    endfunction

    // Narrow accesses: a single byte, or an aligned halfword; offset is
    // where the lowest enabled byte sits. Anything else is a full word.
    function automatic void req_shape(input logic [3:0] ws, output logic [2:0] sz, output logic [1:0] off);
        int n;
        int low;
        n   = $countones(ws);
        low = 0;
        for (int i = 3; i >= 0; i--) if (ws[i]) low = i;
        sz  = 3'd2;
        off = 2'd0;
        if (n == 1) begin
            sz = 3'd0; off = 2'(low);
        end else if (ws == 4'b0011 || ws == 4'b1100) begin
            sz = 3'd1; off = 2'(low);
        end
    endfunction

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        pico_mem_valid            = 1'b0;
        pico_mem_addr             = '0;
        pico_mem_wstrb            = '0;
        pico_mem_wdata            = '0;
        pico_mem_amo_op           = '0;
        l15_transducer_ack        = 1'b0;
        l15_transducer_header_ack = 1'b0;
        l15_transducer_val        = 1'b0;
        l15_transducer_returntype = '0;
        l15_transducer_data_0     = '0;
        l15_transducer_data_1     = '0;
    endtask

    // One complete Pico access. extra: 0 none, 1 INT_RET in WAIT, 2 junk return in WAIT.
    task automatic run_txn(input logic [31:0] addr, input logic [3:0] ws, input logic [31:0] wd,
                           input logic [AW-1:0] amo, input int ack_dly, input int ret_dly,
                           input int extra, input logic [63:0] d0, input bit use_hdr);
        bit          is_amo;
        logic [4:0]  exp_rq;
        logic [AW-1:0] exp_amo;
        logic [2:0]  sz;
        logic [1:0]  off;
        logic [PAW-1:0] exp_addr;
        logic [63:0] exp_data;
        logic [3:0]  ret_type;
        logic [31:0] exp_rd;
        logic [31:0] got;
        bit          exp_int;
`ifdef PICO_L15_AMO_EN
        is_amo = (amo != '0);
`else
        is_amo = 1'b0;
`endif
        exp_rq   = is_amo ? 5'd6 : (ws != 4'b0 ? 5'd1 : 5'd0);
        exp_amo  = is_amo ? amo : '0;
        req_shape(ws, sz, off);
        exp_addr = {8'h00, addr[31:2], off};
        exp_data = {swap_bytes(wd), swap_bytes(wd)};
        ret_type = is_amo ? 4'd3 : (ws != 4'b0 ? 4'd4 : 4'd0);
        exp_rd   = (ret_type == 4'd4) ? 32'd0 : swap_bytes(addr[2] ? d0[31:0] : d0[63:32]);
        exp_q.push_back(exp_rd);

        @(negedge clk);
        pico_mem_valid  = 1'b1;
        pico_mem_addr   = addr;
        pico_mem_wstrb  = ws;
        pico_mem_wdata  = wd;
        pico_mem_amo_op = amo;
        @(negedge clk);
        for (int c = 0; c <= ack_dly; c++) begin
            checks++;
            if (transducer_l15_val !== 1'b1 || transducer_l15_rqtype !== exp_rq ||
                transducer_l15_size !== sz || transducer_l15_address !== exp_addr ||
                transducer_l15_nc !== addr[31] || transducer_l15_amo_op !== exp_amo ||
                ((ws != 4'b0 || is_amo) && transducer_l15_data !== exp_data))
                begin
                failures++;
                $display("FAIL req_fields cyc=%0d: val=%b rq=%0d sz=%0d addr=%h nc=%b amo=%h data=%h, want val=1 rq=%0d sz=%0d addr=%h nc=%b amo=%h data=%h",
                         c, transducer_l15_val, transducer_l15_rqtype, transducer_l15_size,
                         transducer_l15_address, transducer_l15_nc, transducer_l15_amo_op, transducer_l15_data,
                         exp_rq, sz, exp_addr, addr[31], exp_amo, exp_data);
            end
            if (c == ack_dly) begin
                if (use_hdr) l15_transducer_header_ack = 1'b1;
                else         l15_transducer_ack        = 1'b1;
            end
            @(negedge clk);
            l15_transducer_ack        = 1'b0;
            l15_transducer_header_ack = 1'b0;
        end
        for (int c = 0; c < ret_dly; c++) begin
            exp_int = (extra == 1 && c == 1);
            checks++;
            if (transducer_l15_val !== 1'b0 || transducer_pico_mem_ready !== 1'b0 ||
                fsm_state !== 2'd2 || pico_int !== exp_int) begin
                failures++;
                $display("FAIL wait_state cyc=%0d: val=%b ready=%b state=%0d int=%b, want val=0 ready=0 state=2 int=%b",
                         c, transducer_l15_val, transducer_pico_mem_ready, fsm_state, pico_int, exp_int);
            end
            if (extra != 0 && c == 0) begin
                l15_transducer_val        = 1'b1;
                l15_transducer_returntype = (extra == 1) ? 4'd7 : 4'd2;
                l15_transducer_data_0     = {$urandom, $urandom};
                #1;
                checks++;
                if (transducer_l15_req_ack !== 1'b1) begin
                    failures++;
                    $display("FAIL side_ret_ack: got %b want 1", transducer_l15_req_ack);
                end
            end
            @(negedge clk);
            l15_transducer_val = 1'b0;
        end
        l15_transducer_val        = 1'b1;
        l15_transducer_returntype = ret_type;
        l15_transducer_data_0     = d0;
        l15_transducer_data_1     = {$urandom, $urandom};
        #1;
        checks++;
        if (transducer_l15_req_ack !== 1'b1 || pico_int !== 1'b0) begin
            failures++;
            $display("FAIL ret_ack: req_ack=%b int=%b want req_ack=1 int=0", transducer_l15_req_ack, pico_int);
        end
        @(negedge clk);
        l15_transducer_val = 1'b0;
        got = transducer_pico_mem_rdata;
        exp_rd = exp_q.pop_front();
        checks++;
        if (transducer_pico_mem_ready !== 1'b1 || got !== exp_rd) begin
            failures++;
            $display("FAIL resp: ready=%b rdata=%h want ready=1 rdata=%h", transducer_pico_mem_ready, got, exp_rd);
        end
        pico_mem_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (transducer_pico_mem_ready !== 1'b0 || fsm_state !== 2'd0 || transducer_l15_val !== 1'b0) begin
            failures++;
            $display("FAIL ready_pulse: ready=%b state=%0d val=%b want 0/0/0",
                     transducer_pico_mem_ready, fsm_state, transducer_l15_val);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (transducer_l15_val !== 1'b0 || transducer_pico_mem_ready !== 1'b0 || pico_int !== 1'b0 ||
            transducer_pico_mem_rdata !== 32'd0 || transducer_l15_rqtype !== 5'd0 ||
            transducer_l15_size !== 3'd0 || transducer_l15_address !== '0 ||
            transducer_l15_data !== 64'd0 || transducer_l15_nc !== 1'b0 ||
            transducer_l15_amo_op !== '0 || fsm_state !== 2'd0) begin
            failures++;
            $display("FAIL reset_outputs: val=%b ready=%b int=%b rdata=%h rq=%0d addr=%h state=%0d want all 0",
                     transducer_l15_val, transducer_pico_mem_ready, pico_int, transducer_pico_mem_rdata,
                     transducer_l15_rqtype, transducer_l15_address, fsm_state);
        end
        checks++;
        if ({transducer_l15_threadid, transducer_l15_prefetch, transducer_l15_invalidate_cacheline,
             transducer_l15_blockstore, transducer_l15_blockinitstore, transducer_l15_l1rplway,
             transducer_l15_data_next_entry, transducer_l15_csm_data} !== '0) begin
            failures++;
            $display("FAIL tie_offs: nonzero constant output, want 0");
        end
        rst = 1'b0;
    endtask

    task automatic test_load();
        run_txn(32'h0000_0104, 4'b0000, 32'h0, '0, 0, 1, 0, 64'h1122_3344_5566_7788, 1'b0);
    endtask

    task automatic test_store_half();
        run_txn(32'h0000_0202, 4'b1100, 32'hAABB_CCDD, '0, 0, 0, 0, 64'h0, 1'b0);
    endtask

    task automatic test_store_byte_nc();
        run_txn(32'h8000_0003, 4'b1000, 32'h1234_5678, '0, 1, 2, 0, 64'h0, 1'b0);
    endtask

    task automatic test_int_in_wait();
        run_txn(32'h0000_0010, 4'b0000, 32'h0, '0, 0, 3, 1, 64'hCAFE_F00D_DEAD_BEEF, 1'b0);
    endtask

    task automatic test_ack_delay();
        run_txn(32'h0000_1238, 4'b1111, 32'h0102_0304, '0, 5, 1, 0, 64'h0, 1'b1);
    endtask

    task automatic test_junk_return();
        run_txn(32'h0000_0020, 4'b0000, 32'h0, '0, 0, 2, 2, 64'h0102_0304_0506_0708, 1'b0);
    endtask

    task automatic test_int_idle();
        @(negedge clk);
        l15_transducer_val        = 1'b1;
        l15_transducer_returntype = 4'd7;
        #1;
        checks++;
        if (transducer_l15_req_ack !== 1'b1) begin
            failures++;
            $display("FAIL int_idle_ack: got %b want 1", transducer_l15_req_ack);
        end
        @(negedge clk);
        l15_transducer_val = 1'b0;
        checks++;
        if (pico_int !== 1'b1 || fsm_state !== 2'd0 || transducer_pico_mem_ready !== 1'b0) begin
            failures++;
            $display("FAIL int_idle_pulse: int=%b state=%0d ready=%b want 1/0/0", pico_int, fsm_state, transducer_pico_mem_ready);
        end
        @(negedge clk);
        checks++;
        if (pico_int !== 1'b0) begin
            failures++;
            $display("FAIL int_idle_drop: int=%b want 0", pico_int);
        end
    endtask

    task automatic test_reset_mid();
        // reset while the request is still being offered
        @(negedge clk);
        pico_mem_valid = 1'b1; pico_mem_addr = 32'h40; pico_mem_wstrb = 4'b0;
        @(negedge clk);
        rst = 1'b1; pico_mem_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (transducer_l15_val !== 1'b0 || fsm_state !== 2'd0) begin
            failures++;
            $display("FAIL rst_in_req: val=%b state=%0d want 0/0", transducer_l15_val, fsm_state);
        end
        rst = 1'b0;
        // reset while waiting for the return
        pico_mem_valid = 1'b1;
        @(negedge clk);
        l15_transducer_ack = 1'b1;
        @(negedge clk);
        l15_transducer_ack = 1'b0;
        rst = 1'b1; pico_mem_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (transducer_l15_val !== 1'b0 || transducer_pico_mem_ready !== 1'b0 || fsm_state !== 2'd0) begin
            failures++;
            $display("FAIL rst_in_wait: val=%b ready=%b state=%0d want 0/0/0",
                     transducer_l15_val, transducer_pico_mem_ready, fsm_state);
        end
        rst = 1'b0;
        // the stale return must be discarded
        l15_transducer_val = 1'b1; l15_transducer_returntype = 4'd0;
        @(negedge clk);
        l15_transducer_val = 1'b0;
        checks++;
        if (transducer_pico_mem_ready !== 1'b0 || fsm_state !== 2'd0) begin
            failures++;
            $display("FAIL stale_ret: ready=%b state=%0d want 0/0", transducer_pico_mem_ready, fsm_state);
        end
        run_txn(32'h0000_0044, 4'b0000, 32'h0, '0, 1, 1, 0, 64'h8899_AABB_CCDD_EEFF, 1'b0);
    endtask

    task automatic test_random();
        logic [3:0] ws_tab [12];
        logic [31:0] a;
        int extra;
        ws_tab = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF, 4'h5, 4'h6, 4'h0, 4'hE};
        for (int i = 0; i < 30; i++) begin
            a     = $urandom;
            extra = $urandom_range(0, 2);
            run_txn(a, ws_tab[$urandom_range(0, 11)], $urandom, AW'($urandom_range(0, 15)),
                    $urandom_range(0, 4), (extra != 0) ? $urandom_range(2, 4) : $urandom_range(0, 3),
                    extra, {$urandom, $urandom}, 1'($urandom_range(0, 1)));
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        idle_inputs();
        rst = 1'b1;
        test_reset();
        test_load();
        test_store_half();
        test_store_byte_nc();
        test_int_in_wait();
        test_ack_delay();
        test_junk_return();
        test_int_idle();
        test_reset_mid();
        test_random();
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_leftover: %0d entries want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
